prog_encoder: RTL
=================

Name: prog_encoder

Overview:
- Writer-side counterpart of the instruction decoder: accepts instruction fields over a valid/ready stream, packs them into the 16-bit instruction format, and writes them sequentially into program memory.
- Instruction format:
  - [15:6] data memory address
  - [5:2] op code, op_code package encoding
  - [1:0] register file address
  - direct LD: [15:8] immediate, [7]=1
- After the last instruction, optionally pads the rest of program memory with NOP words.
- Sits between the program loader (host/UART side) and program memory; the decoder later reads these words.

Parameters:
- PM_ADDR_W, 8, program memory address width.
- PM_DEPTH, 2**PM_ADDR_W, number of program words; legal range 2..2**PM_ADDR_W.
- PAD_EN, 1, 1 = fill unused words with NOP after i_last; 0 = go straight to DONE.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  begin (or restart) a load session at address 0.
- i_valid  in  1  instruction fields valid.
- o_ready  out  1  encoder can accept the fields this cycle.
- i_opcode  in  4  op_code package value.
- i_rf_addr  in  2  register file address.
- i_mem_addr  in  10  data memory address.
- i_direct  in  1  direct (immediate) load request.
- i_direct_data  in  8  immediate value.
- i_last  in  1  this is the final program instruction.
- o_pm_we  out  1  program memory write strobe.
- o_pm_addr  out  PM_ADDR_W  program memory write address.
- o_pm_wdata  out  16  encoded instruction word.
- o_busy  out  1  session in progress (LOAD or PAD).
- o_done  out  1  session finished; level, held until i_start.
- o_overflow  out  1  sticky: memory filled without i_last.
- o_count  out  PM_ADDR_W+1  user words accepted this session, excluding pads.

Behaviour:
- Reset: state IDLE; all outputs 0 (o_ready, o_pm_we, o_pm_addr, o_pm_wdata, o_busy, o_done, o_overflow, o_count); write pointer 0.
- States:
  - IDLE: o_ready=0. i_start -> LOAD.
  - LOAD: o_ready=1. Accept on i_valid && o_ready at the clock edge.
  - PAD: writes NOP words.
  - DONE: o_done=1, o_ready=0. i_start -> LOAD.
- Acceptance in LOAD:
  - The word is written at the pointer value, then the pointer and o_count increment.
  - Accept with i_last: PAD_EN=1 and pointer < PM_DEPTH-1 -> PAD; otherwise -> DONE.
  - Accept at pointer PM_DEPTH-1 without i_last -> DONE with o_overflow=1.
- Write latency: exactly 1 cycle. Acceptance at edge N gives o_pm_we=1 with o_pm_addr/o_pm_wdata valid in cycle N+1. Outputs are registered; o_pm_we is a one-cycle pulse per word.
- Back-to-back: one word per cycle sustained; no bubbles in LOAD.
- Encoding (registered):
  - i_direct=1 and i_opcode==OP_LD: {i_direct_data, 1'b1, 1'b0, i_opcode, i_rf_addr}; i_mem_addr ignored.
  - i_opcode==OP_LD and i_direct=0: {i_mem_addr with bit1 forced 0, i_opcode, i_rf_addr}. Word bit7 must be 0, otherwise the decoder would treat it as a direct load.
  - Any other opcode: {i_mem_addr, i_opcode, i_rf_addr}; i_direct ignored.
- PAD:
  - One NOP word per cycle, {10'b0, OP_NOP, 2'b00}, at pointer..PM_DEPTH-1; o_pm_we=1 each cycle.
  - After the write to PM_DEPTH-1 -> DONE.
  - o_ready=0 throughout; o_count unchanged.
- o_busy=1 in LOAD and PAD only.
- i_start:
  - Any state, including mid-LOAD/PAD: next state LOAD; pointer, o_count, o_done and o_overflow cleared.
  - A write already registered from the previous edge still issues in the next cycle.
  - No acceptance occurs on the i_start cycle; o_ready=0 that cycle.
- i_rst dominates i_start.
- Inputs are don't-care when not accepted. Holding i_valid with o_ready=0 produces no write.

Test Plan:
- Reset: assert i_rst with i_start=1 -> all outputs 0, IDLE. Release, then pulse i_start -> o_ready=1 and o_busy=1 next cycle.
- ALU/STM encode: opcode=OP_STM, mem_addr=10'h2A5, rf=2'b10 accepted at edge N -> cycle N+1: o_pm_we=1, addr=0, wdata={10'h2A5,OP_STM,2'b10}; o_count=1.
- LD encode:
  - direct: OP_LD, i_direct=1, data=8'h5C, rf=01 -> wdata={8'h5C,1,0,OP_LD,2'b01}.
  - non-direct: OP_LD, mem_addr=10'h3FF -> wdata[15:6]=10'h3FD.
  - non-LD opcode with i_direct=1 -> i_direct ignored, mem_addr used.
- Padding: PM_DEPTH=8, 3 back-to-back words with i_last on the third -> writes at addr 0,1,2, then NOP at 3..7 on 5 consecutive cycles -> o_done=1, o_count=3, o_overflow=0.
- Overflow and no-pad: PM_DEPTH=8, 8 words, none with i_last -> DONE, o_overflow=1, o_count=8, no NOP writes. Repeat with PAD_EN=0 and i_last on word 3 -> DONE immediately, no pads.
- Restart and backpressure: i_start during PAD at addr 5 -> the in-flight write completes, then LOAD with addr 0 and o_count=0. Holding i_valid in DONE -> no o_pm_we.

Source files
------------

// File: rtl/prog_encoder.sv
// Program encoder: packs instruction fields from a valid/ready stream into
// 16-bit program words and writes them sequentially into program memory.
module prog_encoder #(
    parameter int PM_ADDR_W = 8,
    parameter int PM_DEPTH  = 2**PM_ADDR_W,
    parameter bit PAD_EN    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [3:0]           i_opcode,
    input  logic [1:0]           i_rf_addr,
    input  logic [9:0]           i_mem_addr,
    input  logic                 i_direct,
    input  logic [7:0]           i_direct_data,
    input  logic                 i_last,
    output logic                 o_pm_we,
    output logic [PM_ADDR_W-1:0] o_pm_addr,
    output logic [15:0]          o_pm_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [PM_ADDR_W:0]   o_count
);

    localparam logic [3:0]           OP_NOP   = 4'h0;
    localparam logic [3:0]           OP_LD    = 4'h1;
    localparam logic [15:0]          NOP_WORD = {10'b0, OP_NOP, 2'b00};
    localparam logic [PM_ADDR_W-1:0] LAST_PTR = PM_ADDR_W'(PM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [PM_ADDR_W-1:0]   r_ptr;
    logic [PM_ADDR_W:0]     r_count;
    logic                   r_overflow;
    logic                   r_pm_we;
    logic [PM_ADDR_W-1:0]   r_pm_addr;
    logic [15:0]            r_pm_wdata;
    logic                   w_accept;
    logic                   w_at_last;

    // Non-direct LD clears address bit 1 so word bit 7 never flags a direct load.
    function automatic logic [15:0] f_encode(
        input logic [3:0] op,
        input logic [1:0] rf,
        input logic [9:0] maddr,
        input logic       direct,
        input logic [7:0] ddata
    );
        logic [15:0] word;
        if (op == OP_LD && direct) begin
            word = {ddata, 1'b1, 1'b0, op, rf};
        end else if (op == OP_LD) begin
            word = {maddr & 10'h3FD, op, rf};
        end else begin
            word = {maddr, op, rf};
        end
        return word;
    endfunction

    assign o_ready   = (r_state == ST_LOAD) && !i_start && !i_rst;
    assign w_accept  = i_valid && o_ready;
    assign w_at_last = (r_ptr == LAST_PTR);

    // Next-state selection; i_start restarts from any state.
    always_comb begin
        w_next_state = r_state;
        if (i_start) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_IDLE;
                ST_LOAD: begin
                    if (w_accept && i_last) begin
                        if (PAD_EN && !w_at_last) begin
                            w_next_state = ST_PAD;
                        end else begin
                            w_next_state = ST_DONE;
                        end
                    end else if (w_accept && w_at_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
                ST_PAD: begin
                    if (w_at_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_PAD;
                    end
                end
                ST_DONE: w_next_state = ST_DONE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write pointer, counters and the registered memory write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= 16'h0000;
        end else begin
            r_pm_we <= 1'b0;
            if (i_start) begin
                r_ptr      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            r_pm_we    <= 1'b1;
                            r_pm_addr  <= r_ptr;
                            r_pm_wdata <= f_encode(i_opcode, i_rf_addr, i_mem_addr,
                                                   i_direct, i_direct_data);
                            r_count    <= r_count + {{PM_ADDR_W{1'b0}}, 1'b1};
                            if (!w_at_last) begin
                                r_ptr <= r_ptr + {{(PM_ADDR_W-1){1'b0}}, 1'b1};
                            end
                            if (w_at_last && !i_last) begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                    ST_PAD: begin
                        r_pm_we    <= 1'b1;
                        r_pm_addr  <= r_ptr;
                        r_pm_wdata <= NOP_WORD;
                        if (!w_at_last) begin
                            r_ptr <= r_ptr + {{(PM_ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        r_ptr <= r_ptr;
                    end
                endcase
            end
        end
    end

    assign o_pm_we    = r_pm_we;
    assign o_pm_addr  = r_pm_addr;
    assign o_pm_wdata = r_pm_wdata;
    assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_PAD);
    assign o_done     = (r_state == ST_DONE);
    assign o_overflow = r_overflow;
    assign o_count    = r_count;

endmodule
